// File: rtl/dsm_sample_scheduler_if.sv
// Sample-source / modulator bus of the DSM sample scheduler.
// master: sources, prescaler and host side; slave: the scheduler.
interface dsm_sample_scheduler_if #(
    parameter int NCH = 4,
    parameter int DW  = 16
);
    localparam int GW = $clog2(NCH);

    logic              en_1m;
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] din;
    logic              miss_clr;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     dsm_data;
    logic              dsm_load;
    logic [GW-1:0]     grant_id;
    logic [7:0]        miss_cnt;
    logic              err_overrun;

    modport master (
        output en_1m, req, din, miss_clr,
        input  ack, dsm_data, dsm_load, grant_id, miss_cnt, err_overrun
    );

    modport slave (
        input  en_1m, req, din, miss_clr,
        output ack, dsm_data, dsm_load, grant_id, miss_cnt, err_overrun
    );
endinterface

// File: rtl/dsm_sample_scheduler.sv
// Round-robin sample scheduler feeding the DSM modulator, one grant per en_1m tick.
// Optional DSM_SCHED_PRIO_EN: source 0 strict priority, others round-robin.
module dsm_sample_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic rst_n,
    input  logic clk50m,
    dsm_sample_scheduler_if.slave bus
);
    localparam int GW = $clog2(NCH);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state, state_next;
    logic [GW-1:0]     grant_id_q;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     idx;
    logic              found;
    logic              grant_en;
    logic              miss_inc;
    logic              overrun_set;
    logic [NCH-1:0]    ack_q;
    logic [DW-1:0]     dsm_data_q;
    logic              dsm_load_q;
    logic [7:0]        miss_cnt_q;
    logic              err_overrun_q;

`ifdef DSM_SCHED_PRIO_EN
    // Pointer over sources 1..NCH-1 only; source-0 grants leave it untouched.
    logic [GW-1:0]     rr_ptr;

    always_comb begin
        winner = grant_id_q;
        idx    = '0;
        found  = 1'b0;
        if (bus.req[0]) begin
            winner = '0;
            found  = 1'b1;
        end else begin
            for (int unsigned i = 1; i < NCH; i++) begin
                idx = GW'(((32'(rr_ptr) - 1 + i) % (NCH - 1)) + 1);
                if (!found && bus.req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= GW'(NCH - 1);
        end else if (grant_en && winner != '0) begin
            rr_ptr <= winner;
        end
    end
`else
    always_comb begin
        winner = grant_id_q;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = GW'((32'(grant_id_q) + i) % NCH);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_en    = 1'b0;
        miss_inc    = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en_1m) begin
                    if (|bus.req) begin
                        grant_en   = 1'b1;
                        state_next = LOAD;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end
            end
            LOAD: begin
                // A tick here is dropped; the current grant still completes.
                overrun_set = bus.en_1m;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            grant_id_q    <= GW'(NCH - 1);
            ack_q         <= '0;
            dsm_data_q    <= '0;
            dsm_load_q    <= 1'b0;
            miss_cnt_q    <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            ack_q      <= '0;
            dsm_load_q <= 1'b0;
            if (grant_en) begin
                grant_id_q <= winner;
            end
            if (state == LOAD) begin
                dsm_data_q <= bus.din[32'(grant_id_q)*DW +: DW];
                dsm_load_q <= 1'b1;
                ack_q      <= {{(NCH-1){1'b0}}, 1'b1} << grant_id_q;
            end
            if (bus.miss_clr) begin
                miss_cnt_q    <= '0;
                err_overrun_q <= 1'b0;
            end else begin
                if (miss_inc && miss_cnt_q != '1) begin
                    miss_cnt_q <= miss_cnt_q + 8'd1;
                end
                if (overrun_set) begin
                    err_overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ack         = ack_q;
    assign bus.dsm_data    = dsm_data_q;
    assign bus.dsm_load    = dsm_load_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.miss_cnt    = miss_cnt_q;
    assign bus.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Directed self-checking bench for dsm_sample_scheduler (NCH=4, DW=16).
// Define DSM_SCHED_PRIO_EN for both RTL and bench to exercise priority mode.
module tb_dsm_sample_scheduler;
    localparam int NCH = 4;
    localparam int DW  = 16;

    logic rst_n;
    logic clk50m;
    int   checks;
    int   errors;
    int   load_count;
    int   loads_before;
    int   exp_g;
    logic [DW-1:0] exp_data [NCH];

    dsm_sample_scheduler_if #(.NCH(NCH), .DW(DW)) ifc ();

    dsm_sample_scheduler #(.NCH(NCH), .DW(DW)) dut (
        .rst_n  (rst_n),
        .clk50m (clk50m),
        .bus    (ifc.slave)
    );

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    always @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            load_count <= load_count;
        end else if (ifc.dsm_load === 1'b1) begin
            load_count <= load_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk50m) rst_n = 1'b0;
        @(negedge clk50m);
        @(negedge clk50m) rst_n = 1'b1;
    endtask

    // Ends on the falling edge where the resulting load is visible.
    task automatic tick();
        @(negedge clk50m) ifc.en_1m = 1'b1;
        @(negedge clk50m) ifc.en_1m = 1'b0;
        @(negedge clk50m);
    endtask

    task automatic check_grant(input string tag, input int g);
        check({tag, "_load"},  32'(ifc.dsm_load), 32'd1);
        check({tag, "_ack"},   32'(ifc.ack), 32'(1 << g));
        check({tag, "_gid"},   32'(ifc.grant_id), 32'(g));
        check({tag, "_data"},  32'(ifc.dsm_data), 32'(exp_data[g]));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        load_count  = 0;
        exp_data[0] = 16'h1234;
        exp_data[1] = 16'hB001;
        exp_data[2] = 16'hC002;
        exp_data[3] = 16'hD003;
        rst_n        = 1'b0;
        ifc.en_1m    = 1'b0;
        ifc.req      = '0;
        ifc.miss_clr = 1'b0;
        ifc.din      = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        repeat (3) @(negedge clk50m);
        check("rst_ack",     32'(ifc.ack), 32'd0);
        check("rst_load",    32'(ifc.dsm_load), 32'd0);
        check("rst_data",    32'(ifc.dsm_data), 32'd0);
        check("rst_gid",     32'(ifc.grant_id), 32'd3);
        check("rst_miss",    32'(ifc.miss_cnt), 32'd0);
        check("rst_overrun", 32'(ifc.err_overrun), 32'd0);
        @(negedge clk50m) rst_n = 1'b1;

        // Single grant, then verify the strobe lasts one cycle only
        ifc.req = 4'b0001;
        tick();
        check_grant("first", 0);
        @(negedge clk50m);
        check("first_hold_load", 32'(ifc.dsm_load), 32'd0);
        check("first_hold_ack",  32'(ifc.ack), 32'd0);
        check("first_hold_data", 32'(ifc.dsm_data), 32'h1234);
        ifc.req = '0;

        // All sources requesting across 8 ticks
        apply_reset();
        ifc.req      = 4'b1111;
        loads_before = load_count;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef DSM_SCHED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % NCH;
`endif
            check_grant("rr", exp_g);
        end
        @(negedge clk50m);
        check("rr_loads", 32'(load_count - loads_before), 32'd8);
        ifc.req = '0;

        // Idle ticks: saturation and clear priority
        loads_before = load_count;
        for (int i = 0; i < 255; i++) tick();
        check("miss_255", 32'(ifc.miss_cnt), 32'd255);
        for (int i = 0; i < 45; i++) tick();
        check("miss_sat", 32'(ifc.miss_cnt), 32'd255);
        check("miss_noload", 32'(load_count - loads_before), 32'd0);
        @(negedge clk50m) begin
            ifc.en_1m    = 1'b1;
            ifc.miss_clr = 1'b1;
        end
        @(negedge clk50m) begin
            ifc.en_1m    = 1'b0;
            ifc.miss_clr = 1'b0;
        end
        check("miss_clr", 32'(ifc.miss_cnt), 32'd0);

        // Back-to-back tick during LOAD
        loads_before = load_count;
        @(negedge clk50m) begin
            ifc.req   = 4'b0010;
            ifc.en_1m = 1'b1;
        end
        @(negedge clk50m);
        @(negedge clk50m) ifc.en_1m = 1'b0;
        check_grant("ovr", 1);
        check("ovr_flag", 32'(ifc.err_overrun), 32'd1);
        ifc.req = '0;
        repeat (5) @(negedge clk50m);
        check("ovr_loads",  32'(load_count - loads_before), 32'd1);
        check("ovr_sticky", 32'(ifc.err_overrun), 32'd1);
        check("ovr_nomiss", 32'(ifc.miss_cnt), 32'd0);
        @(negedge clk50m) ifc.miss_clr = 1'b1;
        @(negedge clk50m) ifc.miss_clr = 1'b0;
        check("ovr_clr", 32'(ifc.err_overrun), 32'd0);

        // Reset while the FSM is in LOAD
        ifc.req = 4'b0100;
        @(negedge clk50m) ifc.en_1m = 1'b1;
        @(negedge clk50m) ifc.en_1m = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rstl_ack",  32'(ifc.ack), 32'd0);
        check("rstl_load", 32'(ifc.dsm_load), 32'd0);
        check("rstl_data", 32'(ifc.dsm_data), 32'd0);
        check("rstl_gid",  32'(ifc.grant_id), 32'd3);
        loads_before = load_count;
        @(negedge clk50m) begin
            rst_n   = 1'b1;
            ifc.req = '0;
        end
        repeat (4) @(negedge clk50m);
        check("rstl_lost", 32'(load_count - loads_before), 32'd0);
        ifc.req = 4'b1000;
        tick();
        check_grant("rstl_next", 3);
        ifc.req = '0;

`ifdef DSM_SCHED_PRIO_EN
        apply_reset();
        ifc.req = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("prio0", 0);
        end
        ifc.req = 4'b0110;
        tick();
        check_grant("prio_rr_a", 1);
        tick();
        check_grant("prio_rr_b", 2);
        tick();
        check_grant("prio_rr_c", 1);
        ifc.req = '0;
`endif

        repeat (2) @(negedge clk50m);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
